// File: rtl/otter_csr_pkg.sv
// Shared definitions for the OTTER machine-mode CSR / interrupt unit:
// CSR addresses, operation encoding, mstatus bit positions and the
// fixed-priority interrupt encoder.
package otter_csr_pkg;

  // Machine-mode CSR addresses
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MIP       = 12'h344;

  // Writable counters
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

  // Read-only user-level counter aliases
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_t;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int IRQ_CAUSE_BASE = 16;

  typedef struct packed {
    logic       valid;
    logic [3:0] idx;
  } irq_win_t;

  // Lowest-numbered requesting source wins
  function automatic irq_win_t irq_prio_enc(input logic [15:0] req);
    irq_win_t win;
    win.valid = 1'b0;
    win.idx   = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (req[i]) begin
        win.valid = 1'b1;
        win.idx   = 4'(i);
      end else begin
        win = win;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/otter_csr_counter64.sv
// 64-bit free-running counter with independently writable 32-bit halves.
// A write to either half takes precedence over the increment that cycle,
// so software sees exactly the value it wrote.
module otter_csr_counter64 (
  input  logic        CSR_clk,
  input  logic        CSR_reset_n,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wd,
  output logic [63:0] value
);

  logic [63:0] cnt_r;
  logic [63:0] cnt_nx_s;

  // Next count: software write replaces its half and suppresses the increment
  always_comb begin
    cnt_nx_s = cnt_r;
    if (wr_lo || wr_hi) begin
      if (wr_lo) begin
        cnt_nx_s[31:0] = wd;
      end else begin
        cnt_nx_s[31:0] = cnt_r[31:0];
      end
      if (wr_hi) begin
        cnt_nx_s[63:32] = wd;
      end else begin
        cnt_nx_s[63:32] = cnt_r[63:32];
      end
    end else if (inc) begin
      cnt_nx_s = cnt_r + 64'd1;
    end else begin
      cnt_nx_s = cnt_r;
    end
  end

  // Counter state register
  always_ff @(posedge CSR_clk or negedge CSR_reset_n) begin
    if (!CSR_reset_n) begin
      cnt_r <= 64'd0;
    end else begin
      cnt_r <= cnt_nx_s;
    end
  end

  assign value = cnt_r;

endmodule

// File: rtl/otter_csr_irq.sv
// OTTER machine-mode CSR file with NUM_IRQ edge-captured interrupt sources,
// fixed-priority arbitration, direct/vectored mtvec and 64-bit counters.
module otter_csr_irq
  import otter_csr_pkg::*;
#(
  parameter int          NUM_IRQ     = 4,
  parameter int          VECTORED_EN = 1,
  parameter logic [31:0] RESET_MTVEC = 32'h0
) (
  input  logic               CSR_clk,
  input  logic               CSR_reset_n,
  input  logic [NUM_IRQ-1:0] CSR_irq,
  input  logic [11:0]        CSR_addr,
  input  logic [1:0]         CSR_op,
  input  logic [31:0]        CSR_WD,
  input  logic [31:0]        CSR_pc,
  input  logic               CSR_int_taken,
  input  logic               CSR_mret_exec,
  input  logic               CSR_instret,
  output logic               CSR_int_req,
  output logic [31:0]        CSR_trap_pc,
  output logic [31:0]        CSR_mepc,
  output logic [31:0]        CSR_RD,
  output logic               CSR_illegal
);

  // mtvec bit 1 never holds a value; bit 0 only when vectored mode is allowed
  localparam logic [31:0] MTVEC_MASK = (VECTORED_EN != 0) ? 32'hFFFF_FFFD : 32'hFFFF_FFFC;

  logic [NUM_IRQ-1:0] mie_r;
  logic [NUM_IRQ-1:0] pend_r;
  logic [NUM_IRQ-1:0] irq_prev_r;
  logic [NUM_IRQ-1:0] edge_s;
  logic [NUM_IRQ-1:0] pend_nx_s;
  logic               mstatus_mie_r;
  logic               mstatus_mpie_r;
  logic [31:0]        mtvec_r;
  logic [31:0]        mscratch_r;
  logic [31:0]        mepc_r;
  logic [31:0]        mcause_r;
  logic [63:0]        mcycle_s;
  logic [63:0]        minstret_s;

  logic [31:0] mie_full_s;
  logic [31:0] mip_full_s;
  logic [31:0] mstatus_full_s;
  logic [31:0] rd_s;
  logic [31:0] wv_s;
  logic [31:0] vec_off_s;
  logic [15:0] win_req_s;
  logic [15:0] clr_s;
  logic        mapped_s;
  logic        ro_s;
  logic        illegal_s;
  logic        wr_en_s;
  logic        take_s;
  logic        int_req_s;
  irq_win_t    win_s;
  csr_op_t     op_s;

  assign op_s = csr_op_t'(CSR_op);

  // Widen the packed interrupt state to CSR bit positions and form requests
  always_comb begin
    mie_full_s = 32'd0;
    mie_full_s[IRQ_CAUSE_BASE +: NUM_IRQ] = mie_r;
    mip_full_s = 32'd0;
    mip_full_s[IRQ_CAUSE_BASE +: NUM_IRQ] = pend_r;
    mstatus_full_s = 32'd0;
    mstatus_full_s[MSTATUS_MIE]  = mstatus_mie_r;
    mstatus_full_s[MSTATUS_MPIE] = mstatus_mpie_r;
    win_req_s = 16'd0;
    win_req_s[NUM_IRQ-1:0] = pend_r & mie_r;
  end

  assign win_s     = irq_prio_enc(win_req_s);
  assign int_req_s = mstatus_mie_r & win_s.valid;
  assign take_s    = CSR_int_taken & int_req_s;
  assign edge_s    = CSR_irq & ~irq_prev_r;
  assign vec_off_s = (32'(IRQ_CAUSE_BASE) + {28'd0, win_s.idx}) << 2;

  // Address decode: old CSR value, whether it exists, whether it is read-only
  always_comb begin
    rd_s     = 32'd0;
    mapped_s = 1'b1;
    ro_s     = 1'b0;
    case (CSR_addr)
      CSR_MSTATUS:   rd_s = mstatus_full_s;
      CSR_MIE:       rd_s = mie_full_s;
      CSR_MTVEC:     rd_s = mtvec_r;
      CSR_MSCRATCH:  rd_s = mscratch_r;
      CSR_MEPC:      rd_s = mepc_r;
      CSR_MCAUSE:    rd_s = mcause_r;
      CSR_MIP:       rd_s = mip_full_s;
      CSR_MCYCLE:    rd_s = mcycle_s[31:0];
      CSR_MCYCLEH:   rd_s = mcycle_s[63:32];
      CSR_MINSTRET:  rd_s = minstret_s[31:0];
      CSR_MINSTRETH: rd_s = minstret_s[63:32];
      CSR_CYCLE:     begin rd_s = mcycle_s[31:0];    ro_s = 1'b1; end
      CSR_CYCLEH:    begin rd_s = mcycle_s[63:32];   ro_s = 1'b1; end
      CSR_INSTRET:   begin rd_s = minstret_s[31:0];  ro_s = 1'b1; end
      CSR_INSTRETH:  begin rd_s = minstret_s[63:32]; ro_s = 1'b1; end
      default:       begin rd_s = 32'd0; mapped_s = 1'b0; end
    endcase
  end

  // Write value from the read-modify-write operation
  always_comb begin
    case (op_s)
      CSR_OP_RW: wv_s = CSR_WD;
      CSR_OP_RS: wv_s = rd_s | CSR_WD;
      CSR_OP_RC: wv_s = rd_s & ~CSR_WD;
      default:   wv_s = rd_s;
    endcase
  end

  assign illegal_s = (op_s != CSR_OP_NONE) && (!mapped_s || ro_s);
  assign wr_en_s   = (op_s != CSR_OP_NONE) && !illegal_s;

  // Pending update: software write, then clear of the taken source, then new edges win
  always_comb begin
    clr_s = 16'd0;
    if (take_s) begin
      clr_s[win_s.idx] = 1'b1;
    end else begin
      clr_s = 16'd0;
    end
    if (wr_en_s && (CSR_addr == CSR_MIP)) begin
      pend_nx_s = wv_s[IRQ_CAUSE_BASE +: NUM_IRQ];
    end else begin
      pend_nx_s = pend_r;
    end
    pend_nx_s = (pend_nx_s & ~clr_s[NUM_IRQ-1:0]) | edge_s;
  end

  // Trap-entry state: trap entry beats CSR write beats MRET
  always_ff @(posedge CSR_clk or negedge CSR_reset_n) begin
    if (!CSR_reset_n) begin
      mstatus_mie_r  <= 1'b0;
      mstatus_mpie_r <= 1'b0;
      mepc_r         <= 32'd0;
      mcause_r       <= 32'd0;
    end else begin
      if (take_s) begin
        mstatus_mpie_r <= mstatus_mie_r;
        mstatus_mie_r  <= 1'b0;
      end else if (wr_en_s && (CSR_addr == CSR_MSTATUS)) begin
        mstatus_mie_r  <= wv_s[MSTATUS_MIE];
        mstatus_mpie_r <= wv_s[MSTATUS_MPIE];
      end else if (CSR_mret_exec) begin
        mstatus_mie_r  <= mstatus_mpie_r;
        mstatus_mpie_r <= 1'b1;
      end else begin
        mstatus_mie_r  <= mstatus_mie_r;
        mstatus_mpie_r <= mstatus_mpie_r;
      end
      if (take_s) begin
        mepc_r <= {CSR_pc[31:2], 2'b00};
      end else if (wr_en_s && (CSR_addr == CSR_MEPC)) begin
        mepc_r <= {wv_s[31:2], 2'b00};
      end else begin
        mepc_r <= mepc_r;
      end
      if (take_s) begin
        mcause_r <= 32'h8000_0000 | (32'(IRQ_CAUSE_BASE) + {28'd0, win_s.idx});
      end else if (wr_en_s && (CSR_addr == CSR_MCAUSE)) begin
        mcause_r <= wv_s;
      end else begin
        mcause_r <= mcause_r;
      end
    end
  end

  // Software-only configuration registers
  always_ff @(posedge CSR_clk or negedge CSR_reset_n) begin
    if (!CSR_reset_n) begin
      mie_r      <= '0;
      mtvec_r    <= RESET_MTVEC & MTVEC_MASK;
      mscratch_r <= 32'd0;
    end else begin
      if (wr_en_s && (CSR_addr == CSR_MIE)) begin
        mie_r <= wv_s[IRQ_CAUSE_BASE +: NUM_IRQ];
      end else begin
        mie_r <= mie_r;
      end
      if (wr_en_s && (CSR_addr == CSR_MTVEC)) begin
        mtvec_r <= wv_s & MTVEC_MASK;
      end else begin
        mtvec_r <= mtvec_r;
      end
      if (wr_en_s && (CSR_addr == CSR_MSCRATCH)) begin
        mscratch_r <= wv_s;
      end else begin
        mscratch_r <= mscratch_r;
      end
    end
  end

  // Interrupt edge history and pending flags
  always_ff @(posedge CSR_clk or negedge CSR_reset_n) begin
    if (!CSR_reset_n) begin
      irq_prev_r <= '0;
      pend_r     <= '0;
    end else begin
      irq_prev_r <= CSR_irq;
      pend_r     <= pend_nx_s;
    end
  end

  otter_csr_counter64 u_mcycle (
    .CSR_clk     (CSR_clk),
    .CSR_reset_n (CSR_reset_n),
    .inc         (1'b1),
    .wr_lo       (wr_en_s && (CSR_addr == CSR_MCYCLE)),
    .wr_hi       (wr_en_s && (CSR_addr == CSR_MCYCLEH)),
    .wd          (wv_s),
    .value       (mcycle_s)
  );

  otter_csr_counter64 u_minstret (
    .CSR_clk     (CSR_clk),
    .CSR_reset_n (CSR_reset_n),
    .inc         (CSR_instret),
    .wr_lo       (wr_en_s && (CSR_addr == CSR_MINSTRET)),
    .wr_hi       (wr_en_s && (CSR_addr == CSR_MINSTRETH)),
    .wd          (wv_s),
    .value       (minstret_s)
  );

  assign CSR_int_req = int_req_s;
  assign CSR_trap_pc = mtvec_r[0] ? ({mtvec_r[31:2], 2'b00} + vec_off_s)
                                  : {mtvec_r[31:2], 2'b00};
  assign CSR_mepc    = mepc_r;
  assign CSR_RD      = rd_s;
  assign CSR_illegal = illegal_s;

endmodule

// File: tb/tb_otter_csr_irq.sv
// Scoreboard bench for otter_csr_irq: each stimulus cycle queues the values
// the DUT outputs must show, which are drained and compared on the falling edge.
module tb_otter_csr_irq;

  localparam int K_RD   = 0;
  localparam int K_ILL  = 1;
  localparam int K_REQ  = 2;
  localparam int K_TPC  = 3;
  localparam int K_MEPC = 4;

  logic        CSR_clk       = 1'b0;
  logic        CSR_reset_n   = 1'b0;
  logic [3:0]  CSR_irq       = 4'd0;
  logic [11:0] CSR_addr      = 12'd0;
  logic [1:0]  CSR_op        = 2'b00;
  logic [31:0] CSR_WD        = 32'd0;
  logic [31:0] CSR_pc        = 32'd0;
  logic        CSR_int_taken = 1'b0;
  logic        CSR_mret_exec = 1'b0;
  logic        CSR_instret   = 1'b0;
  logic        CSR_int_req;
  logic [31:0] CSR_trap_pc;
  logic [31:0] CSR_mepc;
  logic [31:0] CSR_RD;
  logic        CSR_illegal;

  int n_checks = 0;
  int n_errors = 0;

  string       tag_q[$];
  int          kind_q[$];
  logic [31:0] exp_q[$];

  otter_csr_irq #(
    .NUM_IRQ     (4),
    .VECTORED_EN (1),
    .RESET_MTVEC (32'h0000_0100)
  ) dut (
    .CSR_clk       (CSR_clk),
    .CSR_reset_n   (CSR_reset_n),
    .CSR_irq       (CSR_irq),
    .CSR_addr      (CSR_addr),
    .CSR_op        (CSR_op),
    .CSR_WD        (CSR_WD),
    .CSR_pc        (CSR_pc),
    .CSR_int_taken (CSR_int_taken),
    .CSR_mret_exec (CSR_mret_exec),
    .CSR_instret   (CSR_instret),
    .CSR_int_req   (CSR_int_req),
    .CSR_trap_pc   (CSR_trap_pc),
    .CSR_mepc      (CSR_mepc),
    .CSR_RD        (CSR_RD),
    .CSR_illegal   (CSR_illegal)
  );

  always #5 CSR_clk = ~CSR_clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input int kind, input string tag, input logic [31:0] exp);
    kind_q.push_back(kind);
    tag_q.push_back(tag);
    exp_q.push_back(exp);
  endtask

  function automatic logic [31:0] observe(input int kind);
    case (kind)
      K_RD:    return CSR_RD;
      K_ILL:   return {31'd0, CSR_illegal};
      K_REQ:   return {31'd0, CSR_int_req};
      K_TPC:   return CSR_trap_pc;
      K_MEPC:  return CSR_mepc;
      default: return 32'hDEAD_DEAD;
    endcase
  endfunction

  // One cycle: compare queued expectations on negedge, clock, return inputs to idle
  task automatic step();
    string       t;
    int          k;
    logic [31:0] e;
    @(negedge CSR_clk);
    while (kind_q.size() > 0) begin
      k = kind_q.pop_front();
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      check_eq(t, observe(k), e);
    end
    @(posedge CSR_clk);
    #1;
    CSR_op        = 2'b00;
    CSR_addr      = 12'h000;
    CSR_WD        = 32'd0;
    CSR_pc        = 32'd0;
    CSR_int_taken = 1'b0;
    CSR_mret_exec = 1'b0;
    CSR_instret   = 1'b0;
    CSR_irq       = 4'd0;
  endtask

  task automatic drive(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd);
    CSR_op   = op;
    CSR_addr = addr;
    CSR_WD   = wd;
  endtask

  task automatic rd_chk(input logic [11:0] addr, input logic [31:0] exp, input string tag);
    drive(2'b00, addr, 32'd0);
    expect_out(K_RD, tag, exp);
    expect_out(K_ILL, {tag, "_ill"}, 32'd0);
    step();
  endtask

  task automatic wr_chk(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd,
                        input logic [31:0] old, input string tag);
    drive(op, addr, wd);
    expect_out(K_RD, tag, old);
    expect_out(K_ILL, {tag, "_ill"}, 32'd0);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    CSR_reset_n = 1'b0;
    repeat (2) @(posedge CSR_clk);
    #2 CSR_reset_n = 1'b1;
    @(posedge CSR_clk);
    #1;

    expect_out(K_REQ, "rst_req", 32'd0);
    expect_out(K_MEPC, "rst_mepc_out", 32'd0);
    rd_chk(12'h300, 32'h0, "rst_mstatus");
    rd_chk(12'h304, 32'h0, "rst_mie");
    rd_chk(12'h305, 32'h100, "rst_mtvec");
    rd_chk(12'h340, 32'h0, "rst_mscratch");
    rd_chk(12'h341, 32'h0, "rst_mepc");
    rd_chk(12'h342, 32'h0, "rst_mcause");
    rd_chk(12'h344, 32'h0, "rst_mip");
    rd_chk(12'hB02, 32'h0, "rst_minstret");
    rd_chk(12'hB80, 32'h0, "rst_mcycleh");

    // Configure vectored mode, enable sources 1 and 3, global enable
    wr_chk(2'b01, 12'h305, 32'h201, 32'h100, "wr_mtvec");
    wr_chk(2'b01, 12'h304, 32'h000A_0000, 32'h0, "wr_mie");
    wr_chk(2'b01, 12'h300, 32'h8, 32'h0, "wr_mstatus");
    rd_chk(12'h305, 32'h201, "rd_mtvec");

    // Simultaneous edges on sources 1 and 3: not visible until next cycle
    CSR_irq = 4'b1010;
    expect_out(K_REQ, "edge_cycle_req", 32'd0);
    step();

    // Source 1 wins; take the trap
    CSR_int_taken = 1'b1;
    CSR_pc        = 32'h0000_1238;
    drive(2'b00, 12'h344, 32'd0);
    expect_out(K_RD, "mip_both", 32'h000A_0000);
    expect_out(K_REQ, "req_pending", 32'd1);
    expect_out(K_TPC, "trap_pc_17", 32'h0000_0244);
    step();

    expect_out(K_MEPC, "mepc_saved", 32'h0000_1238);
    expect_out(K_REQ, "req_after_take", 32'd0);
    rd_chk(12'h342, 32'h8000_0011, "mcause_17");
    rd_chk(12'h300, 32'h80, "mstatus_in_trap");
    rd_chk(12'h344, 32'h0008_0000, "mip_pend3");

    // MRET restores MIE; source 3 then requests
    CSR_mret_exec = 1'b1;
    expect_out(K_REQ, "req_during_mret", 32'd0);
    step();
    expect_out(K_REQ, "req_after_mret", 32'd1);
    expect_out(K_TPC, "trap_pc_19", 32'h0000_024C);
    rd_chk(12'h300, 32'h88, "mstatus_after_mret");

    // Set / clear on mstatus
    wr_chk(2'b01, 12'h300, 32'h0, 32'h88, "mstatus_rw0");
    wr_chk(2'b10, 12'h300, 32'h8, 32'h0, "mstatus_rs");
    expect_out(K_REQ, "req_mie_set", 32'd1);
    wr_chk(2'b11, 12'h300, 32'h8, 32'h8, "mstatus_rc");
    expect_out(K_REQ, "req_mie_clr", 32'd0);
    rd_chk(12'h300, 32'h0, "mstatus_final");

    // Software clear of mip, and clear racing a new edge
    wr_chk(2'b11, 12'h344, 32'h0008_0000, 32'h0008_0000, "mip_rc3");
    rd_chk(12'h344, 32'h0, "mip_cleared");
    CSR_irq = 4'b0001;
    wr_chk(2'b11, 12'h344, 32'h0001_0000, 32'h0, "mip_rc_race");
    rd_chk(12'h344, 32'h0001_0000, "mip_edge_wins");
    wr_chk(2'b11, 12'h344, 32'h0001_0000, 32'h0001_0000, "mip_rc0");
    rd_chk(12'h344, 32'h0, "mip_empty");

    wr_chk(2'b01, 12'h340, 32'hDEAD_BEEF, 32'h0, "wr_mscratch");
    rd_chk(12'h340, 32'hDEAD_BEEF, "rd_mscratch");

    // mcycle carry and write-holds
    drive(2'b01, 12'hB00, 32'hFFFF_FFFF);
    expect_out(K_ILL, "mcycle_lo_ill", 32'd0);
    step();
    wr_chk(2'b01, 12'hB80, 32'h0, 32'h0, "mcycleh_wr");
    rd_chk(12'hB00, 32'hFFFF_FFFF, "mcycle_held");
    rd_chk(12'hB00, 32'h0, "mcycle_wrap");
    rd_chk(12'hB80, 32'h1, "mcycleh_carry");
    rd_chk(12'hC80, 32'h1, "cycleh_alias");

    // minstret counting and write precedence
    for (int i = 0; i < 3; i++) begin
      CSR_instret = 1'b1;
      step();
    end
    rd_chk(12'hB02, 32'd3, "minstret_3");
    CSR_instret = 1'b1;
    wr_chk(2'b01, 12'hB02, 32'd10, 32'd3, "minstret_wr");
    rd_chk(12'hB02, 32'd10, "minstret_held");

    // Illegal accesses leave state untouched
    drive(2'b01, 12'h7C0, 32'h1);
    expect_out(K_ILL, "ill_unmapped", 32'd1);
    expect_out(K_RD, "ill_unmapped_rd", 32'd0);
    step();
    drive(2'b01, 12'hC02, 32'd5);
    expect_out(K_ILL, "ill_alias", 32'd1);
    expect_out(K_RD, "ill_alias_rd", 32'd10);
    step();
    drive(2'b01, 12'hC00, 32'd0);
    expect_out(K_ILL, "ill_cycle_alias", 32'd1);
    step();
    rd_chk(12'hB02, 32'd10, "minstret_unchanged");
    rd_chk(12'h7C0, 32'h0, "unmapped_read");

    // Trap into source 3, then reset in the middle of the next cycle
    wr_chk(2'b01, 12'h300, 32'h8, 32'h0, "mstatus_reen");
    CSR_irq = 4'b1000;
    step();
    CSR_int_taken = 1'b1;
    CSR_pc        = 32'h0000_4000;
    expect_out(K_REQ, "req_src3", 32'd1);
    expect_out(K_TPC, "trap_pc_src3", 32'h0000_024C);
    step();
    expect_out(K_MEPC, "mepc_src3", 32'h0000_4000);
    rd_chk(12'h342, 32'h8000_0013, "mcause_19");

    #2 CSR_reset_n = 1'b0;
    #1;
    check_eq("midreset_mepc", CSR_mepc, 32'd0);
    check_eq("midreset_req", {31'd0, CSR_int_req}, 32'd0);
    @(negedge CSR_clk);
    CSR_reset_n = 1'b1;
    @(posedge CSR_clk);
    #1;
    rd_chk(12'h305, 32'h100, "post_rst_mtvec");
    rd_chk(12'h342, 32'h0, "post_rst_mcause");
    rd_chk(12'h300, 32'h0, "post_rst_mstatus");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/otter_csr_irq.md
# otter_csr_irq

Parametrised machine-mode CSR and interrupt unit for the OTTER MCU. It replaces the single-interrupt CSR file with NUM_IRQ edge-captured interrupt sources and per-source enables. It adds fixed-priority arbitration, mcause reporting, direct/vectored mtvec, set/clear CSR operations, and 64-bit cycle/instret counters. It sits beside the register file and is driven by the control unit FSM, which samples CSR_int_req and returns CSR_int_taken.

## Interface
- NUM_IRQ, 4, number of platform interrupt lines (1..16), mapped to cause/enable bit 16+i
- VECTORED_EN, 1, 1 allows mtvec mode 1 (vectored); 0 forces mtvec[1:0] to read 0
- RESET_MTVEC, 32'h0, mtvec reset value
- CSR_clk  in  1  clock, all state on rising edge
- CSR_reset_n  in  1  asynchronous, active-low reset
- CSR_irq  in  NUM_IRQ  interrupt lines, already synchronised to CSR_clk
- CSR_addr  in  12  CSR address (instruction bits [31:20])
- CSR_op  in  2  00 none, 01 write (RW), 10 set (RS), 11 clear (RC)
- CSR_WD  in  32  operand (rs1 or zimm)
- CSR_pc  in  32  PC to save in mepc on interrupt entry
- CSR_int_taken  in  1  core is entering the trap this cycle
- CSR_mret_exec  in  1  MRET retiring this cycle
- CSR_instret  in  1  one-cycle pulse per retired instruction
- CSR_int_req  out  1  interrupt pending and enabled (combinational)
- CSR_trap_pc  out  32  trap target for the current winner (combinational)
- CSR_mepc  out  32  MRET return address
- CSR_RD  out  32  old value of the addressed CSR (combinational)
- CSR_illegal  out  1  CSR_op≠00 to an unmapped address or a write to a read-only CSR

## Operation
- Map: 300 mstatus (MIE bit3, MPIE bit7, other bits read 0), 304 mie, 305 mtvec, 340 mscratch, 341 mepc (bits[1:0] read 0), 342 mcause, 344 mip.
- Counters at B00/B80 mcycle lo/hi and B02/B82 minstret lo/hi.
- Read-only counter aliases at C00/C80/C02/C82. Writing an alias is illegal.
- Unmapped addresses read 0.
- Write value is selected by CSR_op: RW gives WD; RS gives old | WD; RC gives old & ~WD.
- Only implemented bits update. mie and mip hold bits [16+NUM_IRQ-1:16].
- An illegal access changes no state.
- Pending: pend[i] is set on a rising edge of CSR_irq[i], using a registered previous value. It is cleared when source i is taken or by a software RC/RW on mip.
- Winner: the lowest i with pend[i] & mie[16+i].
- CSR_int_req = mstatus.MIE & (any winner exists).
- Trap target: in mode 0, CSR_trap_pc = {mtvec[31:2],2'b00}. In mode 1, CSR_trap_pc = {mtvec[31:2],2'b00} + 4·(16+winner).
- CSR_int_taken while CSR_int_req=1 does all of the following:
  - mepc ← CSR_pc
  - mcause ← {1'b1, 31'(16+winner)}
  - MPIE ← MIE, then MIE ← 0
  - pend[winner] ← 0
- CSR_int_taken while CSR_int_req=0 is ignored.
- MRET: MIE ← MPIE, MPIE ← 1.
- mcycle increments every cycle. minstret increments when CSR_instret=1. Both wrap 2^64−1 → 0, with a 32-bit carry into the hi half.
- Simultaneous events, in priority order for mstatus/mepc: int_taken > CSR write > MRET.
- A CSR write to a counter half replaces that half. There is no increment that cycle: the written value holds and the other half does not change.
- A new rising edge on source i in the same cycle it is taken sets pend[i] again (set wins; no event lost).
- A software clear of mip[i] in the same cycle as a new edge leaves pend[i]=1.

## Timing
- Reset (async assert, sync-safe deassert) sets all of the following:
  - mstatus, mie, mip/pend, mscratch, mepc, mcause and counters = 0
  - mtvec = RESET_MTVEC (low bits masked per VECTORED_EN)
  - edge-detect history = 0
- Outputs after reset: CSR_int_req=0, CSR_mepc=0, CSR_illegal=0.
- An irq edge at cycle n makes pend visible in cycle n+1. CSR_int_req rises in n+1 if enabled.
- CSR_RD returns the pre-write value in the same cycle. The new value is visible from the next cycle.
- CSR_trap_pc and the mcause winner are taken from the same cycle's state: no skew.
- A reset asserted mid-trap clears everything immediately. There is no partial update.

## Structure
- Package otter_csr_pkg contains:
  - CSR address localparams
  - csr_op_t enum (NONE/RW/RS/RC)
  - MSTATUS_MIE=3 and MSTATUS_MPIE=7
  - IRQ_CAUSE_BASE=16
- Sub-module otter_csr_counter64 is instantiated twice (mcycle, minstret). It has an inc input, lo/hi write enables and data inputs, and a 64-bit value output.
- The priority encoder is a function in the package.

## Test plan
- Reset with RESET_MTVEC=32'h100: all reads 0 except mtvec=0x100; CSR_int_req=0.
- mtvec=0x201 (mode 1), mie=0x000A0000, mstatus=0x8, pulse irq[1] and irq[3] in the same cycle: int_req=1 and trap_pc=0x200+4·17=0x244. After taken: mcause=0x80000011, mepc=CSR_pc, MIE=0, MPIE=1, pend[3] still set.
- Then MRET: MIE=1, MPIE=1. int_req reasserts next cycle and trap_pc=0x24C.
- RS 0x8 then RC 0x8 on mstatus: RD returns 0x0 then 0x8, and final MIE=0.
- Write mcycle lo=0xFFFFFFFF, hi=0: after 1 idle cycle mcycle lo=0 and mcycleh=1. Writing mcycle in a cycle holds the written value.
- op=RW to 0x7C0 or C00: CSR_illegal=1 and no register changes. op=00 to 0x7C0: illegal=0 and RD=0.
